// File: rtl/async_fifo_param.sv
// async_fifo_param: parametrised dual-clock FIFO between a wr_clk producer and an
// rd_clk consumer. Pointers cross domains in Gray code through SYNC_STAGES flops;
// each side keeps its own registered flags, occupancy count and sticky error flag.
module async_fifo_param #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int AFULL_TH    = 6,
  parameter int AEMPTY_TH   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              rd_clk,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int              DEPTH        = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_AFULL_TH  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] LP_AEMPTY_TH = (ADDR_W+1)'(AEMPTY_TH);

  // Binary to Gray: adjacent pointer values differ in exactly one bit.
  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits above and including it.
  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Storage shared by both domains; never reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write-domain state
  logic [ADDR_W:0] r_wrBin;
  logic [ADDR_W:0] r_wrGray;
  logic [ADDR_W:0] r_rqSync [SYNC_STAGES];
  logic            r_full;
  logic            r_almostFull;
  logic [ADDR_W:0] r_wrCount;
  logic            r_overflow;

  // Read-domain state
  logic [SYNC_STAGES-1:0] r_rdRstSync;
  logic [ADDR_W:0]        r_rdBin;
  logic [ADDR_W:0]        r_rdGray;
  logic [ADDR_W:0]        r_wqSync [SYNC_STAGES];
  logic [DATA_W-1:0]      r_rdData;
  logic                   r_rdValid;
  logic                   r_empty;
  logic                   r_almostEmpty;
  logic [ADDR_W:0]        r_rdCount;
  logic                   r_underflow;

  // Write-domain combinational next-state
  logic            w_wrAccept;
  logic [ADDR_W:0] w_wrBinNext;
  logic [ADDR_W:0] w_wrGrayNext;
  logic [ADDR_W:0] w_rqGray;
  logic [ADDR_W:0] w_rqBin;
  logic [ADDR_W:0] w_wrCountNext;
  logic [ADDR_W:0] w_fullGray;

  // Read-domain combinational next-state
  logic            w_rdRst;
  logic            w_rdAccept;
  logic [ADDR_W:0] w_rdBinNext;
  logic [ADDR_W:0] w_rdGrayNext;
  logic [ADDR_W:0] w_wqGray;
  logic [ADDR_W:0] w_wqBin;
  logic [ADDR_W:0] w_rdCountNext;

  // ---------------------------------------------------------------------------
  // Write domain
  // ---------------------------------------------------------------------------

  assign w_wrAccept    = wr_en & ~r_full;
  assign w_wrBinNext   = r_wrBin + {{ADDR_W{1'b0}}, w_wrAccept};
  assign w_wrGrayNext  = bin2gray(w_wrBinNext);
  assign w_rqGray      = r_rqSync[SYNC_STAGES-1];
  assign w_rqBin       = gray2bin(w_rqGray);
  assign w_wrCountNext = w_wrBinNext - w_rqBin;
  // The write pointer is exactly one lap ahead of the read pointer when its Gray
  // code equals the read Gray code with the top two bits inverted.
  assign w_fullGray    = {~w_rqGray[ADDR_W:ADDR_W-1], w_rqGray[ADDR_W-2:0]};

  // Bring the read-side Gray pointer into wr_clk through the synchroniser chain.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_rqSync[i] <= '0;
    end else begin
      r_rqSync[0] <= r_rdGray;
      for (int i = 1; i < SYNC_STAGES; i++) r_rqSync[i] <= r_rqSync[i-1];
    end
  end

  // Advance the write pointer and register the write-side flags from next-state values.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      r_wrBin      <= '0;
      r_wrGray     <= '0;
      r_full       <= 1'b0;
      r_almostFull <= 1'b0;
      r_wrCount    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wrBin      <= w_wrBinNext;
      r_wrGray     <= w_wrGrayNext;
      r_full       <= (w_wrGrayNext == w_fullGray);
      r_almostFull <= (w_wrCountNext >= LP_AFULL_TH);
      r_wrCount    <= w_wrCountNext;
      if (wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  // Store accepted write data at the current write address.
  always_ff @(posedge wr_clk) begin
    if (!reset && w_wrAccept) r_mem[r_wrBin[ADDR_W-1:0]] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Read domain
  // ---------------------------------------------------------------------------

  assign w_rdRst       = r_rdRstSync[SYNC_STAGES-1];
  assign w_rdAccept    = rd_en & ~r_empty;
  assign w_rdBinNext   = r_rdBin + {{ADDR_W{1'b0}}, w_rdAccept};
  assign w_rdGrayNext  = bin2gray(w_rdBinNext);
  assign w_wqGray      = r_wqSync[SYNC_STAGES-1];
  assign w_wqBin       = gray2bin(w_wqGray);
  assign w_rdCountNext = w_wqBin - w_rdBinNext;

  // Carry the wr_clk reset into rd_clk so the read side leaves reset cleanly.
  always_ff @(posedge rd_clk) begin
    r_rdRstSync <= {r_rdRstSync[SYNC_STAGES-2:0], reset};
  end

  // Bring the write-side Gray pointer into rd_clk through the synchroniser chain.
  always_ff @(posedge rd_clk) begin
    if (w_rdRst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_wqSync[i] <= '0;
    end else begin
      r_wqSync[0] <= r_wrGray;
      for (int i = 1; i < SYNC_STAGES; i++) r_wqSync[i] <= r_wqSync[i-1];
    end
  end

  // Advance the read pointer, capture read data and register the read-side flags.
  always_ff @(posedge rd_clk) begin
    if (w_rdRst) begin
      r_rdBin       <= '0;
      r_rdGray      <= '0;
      r_rdData      <= '0;
      r_rdValid     <= 1'b0;
      r_empty       <= 1'b1;
      r_almostEmpty <= 1'b1;
      r_rdCount     <= '0;
      r_underflow   <= 1'b0;
    end else begin
      r_rdBin       <= w_rdBinNext;
      r_rdGray      <= w_rdGrayNext;
      r_rdValid     <= w_rdAccept;
      if (w_rdAccept) r_rdData <= r_mem[r_rdBin[ADDR_W-1:0]];
      r_empty       <= (w_rdGrayNext == w_wqGray);
      r_almostEmpty <= (w_rdCountNext <= LP_AEMPTY_TH);
      r_rdCount     <= w_rdCountNext;
      if (rd_en && r_empty) r_underflow <= 1'b1;
    end
  end

  assign full         = r_full;
  assign almost_full  = r_almostFull;
  assign wr_count     = r_wrCount;
  assign overflow     = r_overflow;
  assign rd_data      = r_rdData;
  assign rd_valid     = r_rdValid;
  assign empty        = r_empty;
  assign almost_empty = r_almostEmpty;
  assign rd_count     = r_rdCount;
  assign underflow    = r_underflow;

endmodule
